// File: rtl/mdu_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: IR taps and flush in, stage strobes and MDU status out.
interface mdu_hazard_ctrl_if;
  logic [31:0] IR_D_in;
  logic [31:0] IR_E_in;
  logic [31:0] IR_M_in;
  logic        flush;
  logic        PC_en;
  logic        IF_ID_en;
  logic        IF_ID_clr;
  logic        ID_EX_clr;
  logic        EX_MEM_clr;
  logic        md_start;
  logic        md_busy;
  logic        md_done;

  modport master (
    output IR_D_in, IR_E_in, IR_M_in, flush,
    input  PC_en, IF_ID_en, IF_ID_clr, ID_EX_clr, EX_MEM_clr,
    input  md_start, md_busy, md_done
  );

  modport slave (
    input  IR_D_in, IR_E_in, IR_M_in, flush,
    output PC_en, IF_ID_en, IF_ID_clr, ID_EX_clr, EX_MEM_clr,
    output md_start, md_busy, md_done
  );
endinterface

// File: rtl/mdu_hazard_ctrl.sv
// Hazard detection for the 5-stage MIPS core plus HI/LO unit busy tracking.
// Stage strobes are combinational; only the MDU counter and done flag are state.
module mdu_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  mdu_hazard_ctrl_if.slave  bus
);
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 5;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic logic is_mdop(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn inside {6'h10, 6'h11, 6'h12, 6'h13});
  endfunction

  function automatic logic is_branch(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h04) || (op == 6'h05) || ((op == 6'h00) && (fn == 6'h08));
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return !(op inside {6'h02, 6'h03, 6'h0F});
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h04, 6'h05, 6'h2B, 6'h29, 6'h28};
  endfunction

  // Destination register; 0 doubles as "writes nothing".
  function automatic logic [RW-1:0] wr_reg(input logic [5:0] op, input logic [RW-1:0] rt,
                                           input logic [RW-1:0] rd, input logic [5:0] fn);
    logic [RW-1:0] w;
    w = '0;
    if (op == 6'h00) begin
      if (!(fn inside {6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13})) w = rd;
    end else if ((op >= 6'h08 && op <= 6'h0F) || is_load(op)) begin
      w = rt;
    end else if (op == 6'h03) begin
      w = RW'(31);
    end
    return w;
  endfunction

  logic [5:0]    op_d, fn_d, op_e, fn_e, op_m;
  logic [RW-1:0] rs_d, rt_d, rt_e, rd_e, rt_m, wr_e;
  logic          rs_used, rt_used, br_d;
  logic          stall_lu, stall_br_e, stall_br_m, stall_mdu, stall;
  logic [CW-1:0] cnt;
  logic          start, busy;
  logic          unused_ir;

  assign op_d = bus.IR_D_in[31:26];
  assign rs_d = bus.IR_D_in[25:21];
  assign rt_d = bus.IR_D_in[20:16];
  assign fn_d = bus.IR_D_in[5:0];
  assign op_e = bus.IR_E_in[31:26];
  assign rt_e = bus.IR_E_in[20:16];
  assign rd_e = bus.IR_E_in[15:11];
  assign fn_e = bus.IR_E_in[5:0];
  assign op_m = bus.IR_M_in[31:26];
  assign rt_m = bus.IR_M_in[20:16];

  assign unused_ir = ^{bus.IR_D_in[15:6], bus.IR_E_in[25:21], bus.IR_E_in[10:6],
                       bus.IR_M_in[25:21], bus.IR_M_in[15:0]};

  assign rs_used = uses_rs(op_d);
  assign rt_used = uses_rt(op_d);
  assign br_d    = is_branch(op_d, fn_d);
  assign wr_e    = wr_reg(op_e, rt_e, rd_e, fn_e);

  // Hazard terms; a zero producer register never creates a dependency.
  always_comb begin
    stall_lu   = 1'b0;
    stall_br_e = 1'b0;
    stall_br_m = 1'b0;
    stall_mdu  = 1'b0;
    if (is_load(op_e) && (rt_e != '0))
      stall_lu = (rs_used && (rs_d == rt_e)) || (rt_used && (rt_d == rt_e));
    if (br_d && (wr_e != '0))
      stall_br_e = (rs_used && (rs_d == wr_e)) || (rt_used && (rt_d == wr_e));
    if (br_d && is_load(op_m) && (rt_m != '0))
      stall_br_m = (rs_used && (rs_d == rt_m)) || (rt_used && (rt_d == rt_m));
    if (is_mdop(op_d, fn_d) || is_hilo(op_d, fn_d))
      stall_mdu = busy;
  end

  assign stall = stall_lu | stall_br_e | stall_br_m | stall_mdu;
  assign start = is_mdop(op_e, fn_e) & ~bus.flush;
  assign busy  = (cnt != '0) | start;

  assign bus.PC_en      = ~stall | bus.flush;
  assign bus.IF_ID_en   = ~stall | bus.flush;
  assign bus.ID_EX_clr  = stall | bus.flush;
  assign bus.IF_ID_clr  = bus.flush;
  assign bus.EX_MEM_clr = bus.flush;
  assign bus.md_start   = start;
  assign bus.md_busy    = busy;

  // A start always reloads, even over a running count; flush never aborts a count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bus.md_done <= 1'b0;
    end else begin
      bus.md_done <= (cnt == CW'(1)) & ~start;
      if (start)
        cnt <= (fn_e[1] == 1'b0) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end
endmodule
